ex_stage_mc: RTL and testbench
==============================

# ex_stage_mc

Parametrised execute stage for the five-stage pipeline, replacing the fixed 32-bit single-cycle EX stage. It registers the ID/EX control and data into the EX/MEM pipeline register and evaluates ALU operations and beq/bne resolution in one cycle. Unsigned divide and remainder run on an iterative multi-cycle divider, which stalls the front end through a ready/valid handshake. It sits between the decode stage (DX_* signals) and the memory stage (XM_* signals), and adds a flush input for branch recovery.

## Interface
Parameters:
- XLEN, 32: datapath width; legal values are 8 to 64.
- IMM_W, 16: immediate width; the branch offset is the sign-extended immediate shifted left by 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  the DX_* inputs hold a real instruction
- in_ready  out  1  the stage can accept an instruction on this edge
- flush  in  1  synchronous kill of any in-flight divide and of the instruction presented this cycle
- dx_memtoreg, dx_regwrite, dx_memread, dx_memwrite  in  1 each  control bits, passed through
- dx_branch  in  1  the instruction is a conditional branch
- dx_br_ne  in  1  branch sense: 0 = beq, 1 = bne
- alu_op  in  4  operation code (listed under Operation)
- npc  in  XLEN  PC+4 of the instruction
- a, b  in  XLEN  operands
- imm  in  IMM_W  immediate
- dx_rd  in  5  destination register
- dx_md  in  XLEN  store data
- xm_valid  out  1  the EX/MEM register holds a real instruction
- xm_memtoreg, xm_regwrite, xm_memread, xm_memwrite  out  1 each  registered control bits
- xm_branch  out  1  branch taken
- xm_bt  out  XLEN  branch target
- alu_out  out  XLEN  registered result
- xm_rd  out  5  registered destination register
- xm_md  out  XLEN  registered store data
- busy  out  1  a divide is in flight

## Operation
- alu_op encodings:
  - AND = 0, OR = 1, ADD = 2, XOR = 3
  - DIVU = 4, REMU = 5, SUB = 6, SLT = 7 (signed compare; 1 or 0)
  - SLL = 8, SRL = 9 (shift amount is b[log2(XLEN)-1:0])
  - any other code gives result 0
- Accept condition: in_valid && in_ready && !flush.
- Single-cycle op accepted: the XM register loads all control bits, alu_out, xm_rd and xm_md, and sets xm_valid = 1.
- xm_branch = dx_branch && (dx_br_ne ? a != b : a == b).
- xm_bt = npc + (sext(imm) << 2), truncated to XLEN bits.
- Accept with no branch: xm_branch = 0.
- No accept: a bubble is loaded. xm_valid, xm_regwrite, xm_memread, xm_memwrite and xm_branch become 0; the data fields hold their previous values.
- in_ready = !busy.
- DIVU/REMU accepted:
  - The divider loads, busy rises, and a bubble is loaded into XM.
  - The divider is restoring, one quotient bit per cycle, XLEN iterations.
  - On completion the XM register loads the captured control bits, rd and md, plus the quotient (DIVU) or remainder (REMU), with xm_valid = 1 and xm_branch = 0.
  - busy then falls.
- Divide by zero: quotient is all ones and remainder is a. The divider still takes the full XLEN iterations, so latency does not depend on the data.
- Divider FSM:
  - IDLE → RUN on a divide accept.
  - RUN counts iterations XLEN-1 down to 0. RUN → DONE when the count reaches 0.
  - DONE writes XM and returns to IDLE.
- flush:
  - Has priority over every other event.
  - Forces IDLE and loads a bubble into XM.
  - Takes effect even in the same cycle as a divide completion; the divide result is discarded.
- Async reset while a divide is in flight drops it immediately; no partial result appears.

## Timing
- Reset values: all outputs 0, except in_ready = 1. busy = 0, FSM in IDLE.
- Single-cycle op: the result is visible after the accepting edge (latency 1), at full throughput.
- Divide accepted at edge E0:
  - busy = 1 and in_ready = 0 from E0 until edge E0+XLEN+1.
  - The result is written at E0+XLEN+1, with xm_valid = 1 for that one cycle.
  - busy falls at E0+XLEN+1, so the next accept can occur at edge E0+XLEN+2.
- While busy, in_valid is ignored. Upstream holds the DX_* inputs stable until in_ready is high.

## Structure
- Shared package ex_pkg holds:
  - the alu_op localparams (OP_AND through OP_SRL)
  - the divider state enum: IDLE, RUN, DONE
- Sub-module iter_divu #(XLEN):
  - Ports: start, dividend, divisor, flush, done, quotient, remainder.
  - Contains the FSM and the iteration counter.
- ALU combinational logic and the XM register stay in ex_stage_mc.

## Test plan
- XLEN=32: ADD a=7, b=5 → alu_out=12, xm_valid=1 one cycle later. SUB with a=5, b=7 → 0xFFFFFFFE. SLT with a=-1, b=1 → 1.
- beq a=b=3, npc=0x100, imm=0xFFFF → xm_branch=1, xm_bt=0xFC. Same inputs with dx_br_ne=1 → xm_branch=0.
- DIVU a=100, b=7 → in_ready low for 33 cycles; alu_out=14 at E0+33. REMU with the same operands → 2.
- DIVU with b=0, a=0x1234 → quotient 0xFFFFFFFF. REMU with the same operands → 0x1234. Latency is unchanged.
- flush asserted mid-divide at cycle E0+10 → busy=0 next cycle, no xm_valid pulse, and a new ADD is accepted on the following edge.
- rst_n pulled low mid-divide → all outputs 0 immediately. After release, in_ready=1. Re-run at XLEN=8: DIVU 200/3 → 66 at E0+9.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, divider states, EX/MEM control bundle.
// Used by ex_stage_mc and iter_divu.
package ex_pkg;

   localparam logic [3:0] OP_AND  = 4'd0;
   localparam logic [3:0] OP_OR   = 4'd1;
   localparam logic [3:0] OP_ADD  = 4'd2;
   localparam logic [3:0] OP_XOR  = 4'd3;
   localparam logic [3:0] OP_DIVU = 4'd4;
   localparam logic [3:0] OP_REMU = 4'd5;
   localparam logic [3:0] OP_SUB  = 4'd6;
   localparam logic [3:0] OP_SLT  = 4'd7;
   localparam logic [3:0] OP_SLL  = 4'd8;
   localparam logic [3:0] OP_SRL  = 4'd9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_e;

   typedef struct packed {
      logic       memtoreg;
      logic       regwrite;
      logic       memread;
      logic       memwrite;
      logic [4:0] rd;
   } xm_ctrl_t;

endpackage

// File: rtl/iter_divu.sv
// Restoring unsigned divider, one quotient bit per cycle; start->done takes XLEN+1 edges.
// No backpressure: done is a single-cycle pulse; flush aborts at any point.
module iter_divu
   import ex_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   localparam int CW = $clog2(XLEN);

   div_state_e      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] dvs_q, dvs_d;

   logic [XLEN:0]   trial;
   logic [XLEN:0]   diff;
   logic            ge;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      // Dividend bits shift out of the quotient register into the partial remainder.
      trial   = {rem_q, quo_q[XLEN-1]};
      diff    = trial - {1'b0, dvs_q};
      ge      = (trial >= {1'b0, dvs_q});
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_d = RUN;
                  cnt_d   = CW'(XLEN - 1);
                  rem_d   = '0;
                  quo_d   = dividend;
                  dvs_d   = divisor;
               end
            end
            RUN: begin
               rem_d = ge ? diff[XLEN-1:0] : trial[XLEN-1:0];
               quo_d = {quo_q[XLEN-2:0], ge};
               if (cnt_q == '0) state_d = DONE;
               else             cnt_d   = cnt_q - CW'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/ex_stage_mc.sv
// Execute stage: single-cycle ALU/branch into EX/MEM (latency 1); DIVU/REMU take XLEN+1 cycles.
// Backpressure: in_ready = !busy, so the front end stalls while a divide is in flight.
module ex_stage_mc
   import ex_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int IMM_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             flush,
   input  logic             dx_memtoreg,
   input  logic             dx_regwrite,
   input  logic             dx_memread,
   input  logic             dx_memwrite,
   input  logic             dx_branch,
   input  logic             dx_br_ne,
   input  logic [3:0]       alu_op,
   input  logic [XLEN-1:0]  npc,
   input  logic [XLEN-1:0]  a,
   input  logic [XLEN-1:0]  b,
   input  logic [IMM_W-1:0] imm,
   input  logic [4:0]       dx_rd,
   input  logic [XLEN-1:0]  dx_md,
   output logic             xm_valid,
   output logic             xm_memtoreg,
   output logic             xm_regwrite,
   output logic             xm_memread,
   output logic             xm_memwrite,
   output logic             xm_branch,
   output logic [XLEN-1:0]  xm_bt,
   output logic [XLEN-1:0]  alu_out,
   output logic [4:0]       xm_rd,
   output logic [XLEN-1:0]  xm_md,
   output logic             busy
);

   localparam int SHW = $clog2(XLEN);
   localparam int EW  = (XLEN > IMM_W) ? XLEN : IMM_W;

   logic            accept, is_div, div_start, div_done;
   logic [XLEN-1:0] div_q, div_r;
   logic [XLEN-1:0] alu_res;
   logic            br_taken;
   logic [EW-1:0]   imm_ext;
   logic [XLEN-1:0] br_tgt;
   xm_ctrl_t        dx_ctrl;

   xm_ctrl_t        cap_ctrl_q, cap_ctrl_d;
   logic [XLEN-1:0] cap_md_q, cap_md_d;
   logic            cap_rem_q, cap_rem_d;

   logic            xm_valid_q, xm_valid_d;
   xm_ctrl_t        xm_ctrl_q, xm_ctrl_d;
   logic            xm_branch_q, xm_branch_d;
   logic [XLEN-1:0] xm_bt_q, xm_bt_d;
   logic [XLEN-1:0] alu_out_q, alu_out_d;
   logic [XLEN-1:0] xm_md_q, xm_md_d;

   assign in_ready  = !busy;
   assign accept    = in_valid && in_ready && !flush;
   assign is_div    = (alu_op == OP_DIVU) || (alu_op == OP_REMU);
   assign div_start = accept && is_div;
   assign dx_ctrl   = '{memtoreg: dx_memtoreg, regwrite: dx_regwrite,
                        memread: dx_memread, memwrite: dx_memwrite, rd: dx_rd};

   iter_divu #(.XLEN(XLEN)) u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (div_start),
      .dividend  (a),
      .divisor   (b),
      .flush     (flush),
      .busy      (busy),
      .done      (div_done),
      .quotient  (div_q),
      .remainder (div_r)
   );

   always_comb begin
      alu_res = '0;
      case (alu_op)
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_ADD:  alu_res = a + b;
         OP_XOR:  alu_res = a ^ b;
         OP_SUB:  alu_res = a - b;
         OP_SLT:  alu_res = XLEN'($signed(a) < $signed(b));
         OP_SLL:  alu_res = a << b[SHW-1:0];
         OP_SRL:  alu_res = a >> b[SHW-1:0];
         default: alu_res = '0;
      endcase
   end

   // Immediate is extended to the wider of the two widths so IMM_W > XLEN still truncates cleanly.
   assign imm_ext  = EW'($signed(imm));
   assign br_tgt   = npc + {imm_ext[XLEN-3:0], 2'b00};
   assign br_taken = dx_branch && (dx_br_ne ? (a != b) : (a == b));

   always_comb begin
      cap_ctrl_d = cap_ctrl_q;
      cap_md_d   = cap_md_q;
      cap_rem_d  = cap_rem_q;
      if (div_start) begin
         cap_ctrl_d = dx_ctrl;
         cap_md_d   = dx_md;
         cap_rem_d  = (alu_op == OP_REMU);
      end
   end

   always_comb begin
      // Bubble by default: kill the side-effecting bits, hold the data fields.
      xm_valid_d           = 1'b0;
      xm_branch_d          = 1'b0;
      xm_ctrl_d            = xm_ctrl_q;
      xm_ctrl_d.regwrite   = 1'b0;
      xm_ctrl_d.memread    = 1'b0;
      xm_ctrl_d.memwrite   = 1'b0;
      xm_bt_d              = xm_bt_q;
      alu_out_d            = alu_out_q;
      xm_md_d              = xm_md_q;
      if (!flush) begin
         if (div_done) begin
            xm_valid_d = 1'b1;
            xm_ctrl_d  = cap_ctrl_q;
            alu_out_d  = cap_rem_q ? div_r : div_q;
            xm_md_d    = cap_md_q;
         end else if (accept && !is_div) begin
            xm_valid_d  = 1'b1;
            xm_ctrl_d   = dx_ctrl;
            xm_branch_d = br_taken;
            xm_bt_d     = br_tgt;
            alu_out_d   = alu_res;
            xm_md_d     = dx_md;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_ctrl_q  <= '0;
         cap_md_q    <= '0;
         cap_rem_q   <= 1'b0;
         xm_valid_q  <= 1'b0;
         xm_ctrl_q   <= '0;
         xm_branch_q <= 1'b0;
         xm_bt_q     <= '0;
         alu_out_q   <= '0;
         xm_md_q     <= '0;
      end else begin
         cap_ctrl_q  <= cap_ctrl_d;
         cap_md_q    <= cap_md_d;
         cap_rem_q   <= cap_rem_d;
         xm_valid_q  <= xm_valid_d;
         xm_ctrl_q   <= xm_ctrl_d;
         xm_branch_q <= xm_branch_d;
         xm_bt_q     <= xm_bt_d;
         alu_out_q   <= alu_out_d;
         xm_md_q     <= xm_md_d;
      end
   end

   assign xm_valid    = xm_valid_q;
   assign xm_memtoreg = xm_ctrl_q.memtoreg;
   assign xm_regwrite = xm_ctrl_q.regwrite;
   assign xm_memread  = xm_ctrl_q.memread;
   assign xm_memwrite = xm_ctrl_q.memwrite;
   assign xm_rd       = xm_ctrl_q.rd;
   assign xm_branch   = xm_branch_q;
   assign xm_bt       = xm_bt_q;
   assign alu_out     = alu_out_q;
   assign xm_md       = xm_md_q;

endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed bench for ex_stage_mc at XLEN=32 and XLEN=8.
module tb_ex_stage_mc;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        in_valid, in_ready, flush;
   logic        dx_memtoreg, dx_regwrite, dx_memread, dx_memwrite, dx_branch, dx_br_ne;
   logic [3:0]  alu_op;
   logic [31:0] npc, a, b, dx_md, xm_bt, alu_out, xm_md;
   logic [15:0] imm;
   logic [4:0]  dx_rd, xm_rd;
   logic        xm_valid, xm_memtoreg, xm_regwrite, xm_memread, xm_memwrite, xm_branch, busy;

   logic        in_valid8, in_ready8, xm_valid8, xm_memtoreg8, xm_regwrite8, xm_memread8;
   logic        xm_memwrite8, xm_branch8, busy8;
   logic [3:0]  alu_op8;
   logic [7:0]  a8, b8, xm_bt8, alu_out8, xm_md8;
   logic [4:0]  xm_rd8;

   int checks = 0;
   int failures = 0;
   int low;
   int pulses;

   ex_stage_mc #(.XLEN(32), .IMM_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
      .dx_memtoreg(dx_memtoreg), .dx_regwrite(dx_regwrite), .dx_memread(dx_memread),
      .dx_memwrite(dx_memwrite), .dx_branch(dx_branch), .dx_br_ne(dx_br_ne), .alu_op(alu_op),
      .npc(npc), .a(a), .b(b), .imm(imm), .dx_rd(dx_rd), .dx_md(dx_md),
      .xm_valid(xm_valid), .xm_memtoreg(xm_memtoreg), .xm_regwrite(xm_regwrite),
      .xm_memread(xm_memread), .xm_memwrite(xm_memwrite), .xm_branch(xm_branch),
      .xm_bt(xm_bt), .alu_out(alu_out), .xm_rd(xm_rd), .xm_md(xm_md), .busy(busy)
   );

   ex_stage_mc #(.XLEN(8), .IMM_W(16)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .flush(1'b0),
      .dx_memtoreg(1'b0), .dx_regwrite(1'b1), .dx_memread(1'b0), .dx_memwrite(1'b0),
      .dx_branch(1'b0), .dx_br_ne(1'b0), .alu_op(alu_op8), .npc(8'h00), .a(a8), .b(b8),
      .imm(16'h0000), .dx_rd(5'd1), .dx_md(8'h00),
      .xm_valid(xm_valid8), .xm_memtoreg(xm_memtoreg8), .xm_regwrite(xm_regwrite8),
      .xm_memread(xm_memread8), .xm_memwrite(xm_memwrite8), .xm_branch(xm_branch8),
      .xm_bt(xm_bt8), .alu_out(alu_out8), .xm_rd(xm_rd8), .xm_md(xm_md8), .busy(busy8)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Accepts the divide currently on the inputs and follows it to its single result cycle.
   task automatic run_div(input string tag, input logic [63:0] exp);
      low = 0;
      pulses = 0;
      tick();
      chk({tag, "_busy"}, busy, 1);
      while (!in_ready && low < 100) begin
         low++;
         if (xm_valid) pulses++;
         tick();
      end
      chk({tag, "_lat"}, low, 33);
      chk({tag, "_nopulse"}, pulses, 0);
      chk({tag, "_valid"}, xm_valid, 1);
      chk({tag, "_res"}, alu_out, exp);
   endtask

   initial begin
      in_valid = 0; flush = 0; dx_memtoreg = 0; dx_regwrite = 0; dx_memread = 0;
      dx_memwrite = 0; dx_branch = 0; dx_br_ne = 0; alu_op = 0; npc = 0; a = 0; b = 0;
      imm = 0; dx_rd = 0; dx_md = 0;
      in_valid8 = 0; alu_op8 = 0; a8 = 0; b8 = 0;

      #12;
      chk("rst_valid", xm_valid, 0);
      chk("rst_alu", alu_out, 0);
      chk("rst_bt", xm_bt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", in_ready, 1);
      #11 rst_n = 1;
      tick();

      in_valid = 1; alu_op = 4'd2; a = 7; b = 5; dx_regwrite = 1; dx_rd = 3; dx_md = 32'hAA;
      tick();
      chk("add_res", alu_out, 12);
      chk("add_valid", xm_valid, 1);
      chk("add_rw", xm_regwrite, 1);
      chk("add_rd", xm_rd, 3);
      chk("add_md", xm_md, 32'hAA);

      alu_op = 4'd6; a = 5; b = 7;
      tick();
      chk("sub_res", alu_out, 32'hFFFF_FFFE);
      chk("sub_valid", xm_valid, 1);

      alu_op = 4'd7; a = 32'hFFFF_FFFF; b = 1;
      tick();
      chk("slt_res", alu_out, 1);

      alu_op = 4'd8; a = 1; b = 35;
      tick();
      chk("sll_res", alu_out, 8);

      alu_op = 4'd9; a = 32'h8000_0000; b = 4;
      tick();
      chk("srl_res", alu_out, 32'h0800_0000);

      alu_op = 4'd15; a = 32'h1234; b = 1;
      tick();
      chk("bad_op", alu_out, 0);

      alu_op = 4'd2; dx_branch = 1; dx_br_ne = 0; a = 3; b = 3; npc = 32'h100; imm = 16'hFFFF;
      dx_regwrite = 0;
      tick();
      chk("beq_taken", xm_branch, 1);
      chk("beq_bt", xm_bt, 32'hFC);

      dx_br_ne = 1;
      tick();
      chk("bne_taken", xm_branch, 0);
      chk("bne_bt", xm_bt, 32'hFC);

      in_valid = 0; dx_branch = 0; dx_br_ne = 0;
      tick();
      chk("bub_valid", xm_valid, 0);
      chk("bub_branch", xm_branch, 0);
      chk("bub_hold", alu_out, 6);

      in_valid = 1; alu_op = 4'd4; a = 100; b = 7; dx_regwrite = 1; dx_rd = 9;
      run_div("divu", 14);
      chk("divu_rd", xm_rd, 9);
      chk("divu_busy_after", busy, 0);
      alu_op = 4'd5;
      run_div("remu", 2);

      alu_op = 4'd4; a = 32'h1234; b = 0;
      run_div("divz_q", 32'hFFFF_FFFF);
      alu_op = 4'd5;
      run_div("divz_r", 32'h1234);

      // Flush in the middle of a divide.
      alu_op = 4'd4; a = 100; b = 7;
      tick();
      repeat (9) tick();
      chk("fl_busy_pre", busy, 1);
      flush = 1; in_valid = 0;
      tick();
      chk("fl_busy", busy, 0);
      chk("fl_ready", in_ready, 1);
      chk("fl_valid", xm_valid, 0);
      flush = 0; in_valid = 1; alu_op = 4'd2; a = 1; b = 2;
      tick();
      chk("fl_add_valid", xm_valid, 1);
      chk("fl_add_res", alu_out, 3);
      in_valid = 0;
      pulses = 0;
      repeat (30) begin
         tick();
         if (xm_valid) pulses++;
      end
      chk("fl_no_late", pulses, 0);

      flush = 1; in_valid = 1; alu_op = 4'd2; a = 4; b = 4;
      tick();
      chk("fl_kill_valid", xm_valid, 0);
      chk("fl_kill_hold", alu_out, 3);

      // Flush coinciding with divide completion.
      flush = 0; alu_op = 4'd4; a = 100; b = 7;
      tick();
      in_valid = 0;
      repeat (32) tick();
      chk("fd_busy_pre", busy, 1);
      flush = 1;
      tick();
      chk("fd_valid", xm_valid, 0);
      chk("fd_busy", busy, 0);
      chk("fd_hold", alu_out, 3);
      flush = 0;

      // Asynchronous reset mid-divide.
      in_valid = 1; alu_op = 4'd4; a = 100; b = 7;
      tick();
      repeat (5) tick();
      in_valid = 0;
      #2 rst_n = 0;
      #1;
      chk("ar_busy", busy, 0);
      chk("ar_ready", in_ready, 1);
      chk("ar_alu", alu_out, 0);
      chk("ar_rd", xm_rd, 0);
      chk("ar_bt", xm_bt, 0);
      rst_n = 1;
      tick();
      chk("ar_ready_after", in_ready, 1);
      chk("ar_valid_after", xm_valid, 0);

      // XLEN=8 divide.
      in_valid8 = 1; alu_op8 = 4'd4; a8 = 8'd200; b8 = 8'd3;
      tick();
      in_valid8 = 0;
      chk("d8_busy", busy8, 1);
      low = 0;
      while (!in_ready8 && low < 100) begin
         low++;
         tick();
      end
      chk("d8_lat", low, 9);
      chk("d8_valid", xm_valid8, 1);
      chk("d8_res", alu_out8, 66);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
